// File: rtl/approx_et_sweep_ctrl_if.sv
// Handshake/result bundle between an ET-qualification harness and the sweep controller.
// The harness owns the master side and drives both datapath responses back in.
interface approx_et_sweep_ctrl_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4
);
  logic                    start;
  logic                    abort;
  logic [OUT_W-1:0]        et_thr;
  logic [IN_W-1:0]         dut_in;
  logic [OUT_W-1:0]        exact_out;
  logic [OUT_W-1:0]        approx_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [OUT_W-1:0]        max_err;
  logic [IN_W:0]           viol_cnt;
  logic [IN_W+OUT_W-1:0]   err_sum;

  modport master (
    output start, abort, et_thr, exact_out, approx_out,
    input  dut_in, busy, done, pass, max_err, viol_cnt, err_sum
  );

  modport slave (
    input  start, abort, et_thr, exact_out, approx_out,
    output dut_in, busy, done, pass, max_err, viol_cnt, err_sum
  );
endinterface

// File: rtl/approx_et_sweep_ctrl.sv
// Exhaustive error-threshold sweep: drives every input vector into an exact/approximate
// datapath pair, accumulates worst-case error, violation count and error sum, reports pass.
module approx_et_sweep_ctrl #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4,
  parameter int LAT   = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  approx_et_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_e;

  localparam logic [IN_W-1:0] VEC_LAST = '1;
  localparam logic [2:0]      LAT_M1   = 3'(LAT - 1);

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         vec_q, vec_d;
  logic [2:0]              drn_q, drn_d;
  logic [OUT_W-1:0]        thr_q, thr_d;
  logic [OUT_W-1:0]        max_q, max_d;
  logic [IN_W:0]           viol_q, viol_d;
  logic [IN_W+OUT_W-1:0]   sum_q, sum_d;
  logic                    pass_q, pass_d;

  logic                    busy, go, kill, cmp_vld, upd;
  logic signed [OUT_W:0]   diff;
  logic [OUT_W:0]          mag;
  logic [OUT_W-1:0]        err;

  assign busy = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign go   = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign kill = busy && bus.abort;

  // One extra bit keeps the difference signed so 0 vs 15 yields 15, not a wrapped value.
  assign diff = signed'({1'b0, bus.exact_out}) - signed'({1'b0, bus.approx_out});
  assign mag  = diff[OUT_W] ? unsigned'(-diff) : unsigned'(diff);
  assign err  = mag[OUT_W-1:0];
  assign upd  = cmp_vld && !kill;

  // Compare-valid tracks each issued vector until its response settles LAT cycles later.
  generate
    if (LAT == 0) begin : g_nopipe
      assign cmp_vld = (state_q == S_SWEEP);
    end else begin : g_pipe
      logic [LAT:1] vld_pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe_q <= '0;
        end else if (kill) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[1] <= (state_q == S_SWEEP);
          for (int i = 2; i <= LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
      assign cmp_vld = vld_pipe_q[LAT];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drn_d   = '0;
    thr_d   = thr_q;
    max_d   = max_q;
    viol_d  = viol_q;
    sum_d   = sum_q;
    pass_d  = pass_q;

    if (upd) begin
      if (err > max_q) max_d = err;
      if (err > thr_q) viol_d = viol_q + (IN_W+1)'(1);
      sum_d = sum_q + (IN_W+OUT_W)'(err);
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_SWEEP;
          vec_d   = '0;
          thr_d   = bus.et_thr;
          max_d   = '0;
          viol_d  = '0;
          sum_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_SWEEP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (vec_q == VEC_LAST) begin
          state_d = (LAT > 0) ? S_DRAIN : S_DONE;
        end else begin
          vec_d = vec_q + IN_W'(1);
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (drn_q == LAT_M1) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // The final compare retires on the same edge that enters DONE, so use its next value.
    if (state_d == S_DONE) pass_d = (viol_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      drn_q   <= '0;
      thr_q   <= '0;
      max_q   <= '0;
      viol_q  <= '0;
      sum_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
      thr_q   <= thr_d;
      max_q   <= max_d;
      viol_q  <= viol_d;
      sum_q   <= sum_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.dut_in   = busy ? vec_q : '0;
  assign bus.busy     = busy;
  assign bus.done     = (state_q == S_DONE);
  assign bus.pass     = pass_q;
  assign bus.max_err  = max_q;
  assign bus.viol_cnt = viol_q;
  assign bus.err_sum  = sum_q;

endmodule

// File: tb/tb_approx_et_sweep_ctrl.sv
// Directed bench: one LAT=0 controller with combinational responses and one LAT=2 controller
// whose responses are delayed two cycles; a small madd model provides exact/approx values.
module tb_approx_et_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_et_sweep_ctrl_if #(.IN_W(6), .OUT_W(4)) if0 ();
  approx_et_sweep_ctrl_if #(.IN_W(6), .OUT_W(4)) if2 ();

  approx_et_sweep_ctrl #(.IN_W(6), .OUT_W(4), .LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  approx_et_sweep_ctrl #(.IN_W(6), .OUT_W(4), .LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic       sel = 1'b0;
  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [3:0] thr_r = '0;
  int         mode = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  // exact = a*b + c on 2-bit fields; approx perturbs selected vectors per test mode
  function automatic logic [3:0] f_ex(input logic [5:0] v);
    return 4'(int'(v[5:4]) * int'(v[3:2]) + int'(v[1:0]));
  endfunction

  function automatic logic [3:0] f_ap(input logic [5:0] v, input int m);
    logic [3:0] e;
    e = f_ex(v);
    case (m)
      1:       return (v == 6'd37) ? (e ^ 4'b0100) : e;
      2:       return (v == 6'd0) ? 4'd15 : ((v == 6'd5 || v == 6'd6) ? e + 4'd1 : e);
      default: return e;
    endcase
  endfunction

  assign if0.start  = start_r & ~sel;
  assign if2.start  = start_r & sel;
  assign if0.abort  = abort_r & ~sel;
  assign if2.abort  = abort_r & sel;
  assign if0.et_thr = thr_r;
  assign if2.et_thr = thr_r;

  assign if0.exact_out  = f_ex(if0.dut_in);
  assign if0.approx_out = f_ap(if0.dut_in, mode);

  logic [5:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= if2.dut_in;
    d2 <= d1;
  end
  assign if2.exact_out  = f_ex(d2);
  assign if2.approx_out = f_ap(d2, mode);

  logic       busy_s, done_s, pass_s;
  logic [5:0] din_s;
  logic [3:0] max_s;
  logic [6:0] viol_s;
  logic [9:0] sum_s;
  assign busy_s = sel ? if2.busy     : if0.busy;
  assign done_s = sel ? if2.done     : if0.done;
  assign pass_s = sel ? if2.pass     : if0.pass;
  assign din_s  = sel ? if2.dut_in   : if0.dut_in;
  assign max_s  = sel ? if2.max_err  : if0.max_err;
  assign viol_s = sel ? if2.viol_cnt : if0.viol_cnt;
  assign sum_s  = sel ? if2.err_sum  : if0.err_sum;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int r_done, r_ndone, r_bfirst, r_blast, r_bcnt, r_din1, r_dinl;
  int r_pass, r_max, r_viol, r_sum, r_pass_aft, r_done_aft, r_din_aft;

  // One sweep; cycle 0 is the cycle start is sampled. Bounded to 100 cycles.
  task automatic run(input logic s, input int thr, input int abort_at, input int poke_at);
    sel = s;
    thr_r = 4'(thr);
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    r_done = 0; r_ndone = 0; r_bfirst = 0; r_blast = 0; r_bcnt = 0;
    r_din1 = -1; r_dinl = -1; r_pass = -1; r_max = -1; r_viol = -1; r_sum = -1;
    r_pass_aft = -1; r_done_aft = -1; r_din_aft = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy_s) begin
        if (r_bfirst == 0) r_bfirst = c;
        r_blast = c;
        r_bcnt++;
        r_dinl = int'(din_s);
      end
      if (c == 1) r_din1 = int'(din_s);
      if (done_s) begin
        r_ndone++;
        if (r_done == 0) begin
          r_done = c; r_pass = int'(pass_s); r_max = int'(max_s);
          r_viol = int'(viol_s); r_sum = int'(sum_s);
        end
      end
      if (r_done != 0 && c == r_done + 1) begin
        r_pass_aft = int'(pass_s); r_done_aft = int'(done_s); r_din_aft = int'(din_s);
        break;
      end
      start_r = (c == poke_at);
      abort_r = (c == abort_at);
    end
    start_r = 1'b0;
    abort_r = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_pass", int'(if0.pass), 0);
    chk("rst_din",  int'(if0.dut_in), 0);
    chk("rst_max",  int'(if0.max_err), 0);
    chk("rst_viol", int'(if0.viol_cnt), 0);
    chk("rst_sum",  int'(if0.err_sum), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: identical circuits
    mode = 0;
    run(1'b0, 3, 0, 0);
    chk("t1_done_cyc", r_done, 65);
    chk("t1_bfirst", r_bfirst, 1);
    chk("t1_blast", r_blast, 64);
    chk("t1_bcnt", r_bcnt, 64);
    chk("t1_din1", r_din1, 0);
    chk("t1_dinl", r_dinl, 63);
    chk("t1_pass", r_pass, 1);
    chk("t1_max", r_max, 0);
    chk("t1_viol", r_viol, 0);
    chk("t1_sum", r_sum, 0);
    chk("t1_done_pulse", r_done_aft, 0);
    chk("t1_pass_hold", r_pass_aft, 1);
    chk("t1_din_idle", r_din_aft, 0);

    // T2: single 4-error at vector 37, thresholds 3 and 4
    mode = 1;
    run(1'b0, 3, 0, 0);
    chk("t2a_done_cyc", r_done, 65);
    chk("t2a_max", r_max, 4);
    chk("t2a_viol", r_viol, 1);
    chk("t2a_sum", r_sum, 4);
    chk("t2a_pass", r_pass, 0);
    run(1'b0, 4, 0, 0);
    chk("t2b_pass", r_pass, 1);
    chk("t2b_viol", r_viol, 0);
    chk("t2b_max", r_max, 4);
    chk("t2b_sum", r_sum, 4);

    // T3: absolute error 0 vs 15 plus two off-by-one vectors
    mode = 2;
    run(1'b0, 3, 0, 0);
    chk("t3_max", r_max, 15);
    chk("t3_viol", r_viol, 1);
    chk("t3_sum", r_sum, 17);
    chk("t3_pass", r_pass, 0);

    // T4: LAT=2 build with delayed responses
    mode = 1;
    run(1'b1, 3, 0, 0);
    chk("t4_done_cyc", r_done, 67);
    chk("t4_bfirst", r_bfirst, 1);
    chk("t4_blast", r_blast, 66);
    chk("t4_dinl", r_dinl, 63);
    chk("t4_max", r_max, 4);
    chk("t4_viol", r_viol, 1);
    chk("t4_sum", r_sum, 4);
    chk("t4_pass", r_pass, 0);
    sel = 1'b0;

    // T5: abort at cycle 20 keeps partial results, then a clean rerun with a stray start
    mode = 2;
    run(1'b0, 3, 20, 0);
    chk("t5_blast", r_blast, 20);
    chk("t5_ndone", r_ndone, 0);
    chk("t5_pass", int'(pass_s), 0);
    chk("t5_part_max", int'(max_s), 15);
    chk("t5_part_viol", int'(viol_s), 1);
    chk("t5_part_sum", int'(sum_s), 17);
    @(negedge clk);
    start_r = 1'b1; abort_r = 1'b1;
    @(negedge clk);
    chk("t5_abort_dom", int'(busy_s), 0);
    start_r = 1'b0; abort_r = 1'b0;
    mode = 0;
    run(1'b0, 3, 0, 10);
    chk("t5_rerun_done", r_done, 65);
    chk("t5_rerun_ndone", r_ndone, 1);
    chk("t5_rerun_pass", r_pass, 1);
    chk("t5_rerun_max", r_max, 0);
    chk("t5_rerun_viol", r_viol, 0);
    chk("t5_rerun_sum", r_sum, 0);

    // T6: asynchronous reset in the middle of a sweep
    mode = 2;
    thr_r = 4'd3;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    repeat (29) @(negedge clk);
    chk("t6_pre_din", int'(din_s), 29);
    chk("t6_pre_max", int'(max_s), 15);
    rst_n = 1'b0;
    start_r = 1'b1;
    #1;
    chk("t6_rst_busy", int'(busy_s), 0);
    chk("t6_rst_din", int'(din_s), 0);
    chk("t6_rst_max", int'(max_s), 0);
    chk("t6_rst_viol", int'(viol_s), 0);
    chk("t6_rst_sum", int'(sum_s), 0);
    repeat (3) @(negedge clk);
    chk("t6_start_in_rst", int'(busy_s), 0);
    start_r = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", int'(busy_s), 0);
    run(1'b0, 3, 0, 0);
    chk("t6_done_cyc", r_done, 65);
    chk("t6_max", r_max, 15);
    chk("t6_viol", r_viol, 1);
    chk("t6_sum", r_sum, 17);
    chk("t6_pass", r_pass, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
